// File: rtl/myproject_mac_lanes.sv
// myproject_mac_lanes
// -------------------
// Multi-lane pipelined multiply-accumulate unit. Each of LANES lanes multiplies
// a signed din0 by din1 (signed or zero-extended, see DIN1_SIGNED) and sums the
// products over a packet delimited by in_first / in_last. One full-width sum
// per lane plus a sticky overflow flag is reported on out_valid at packet end.
//
// Pipeline: an operand register, NUM_STAGE product registers, then the
// accumulate/output register. A beat sampled at edge t with in_last=1 raises
// out_valid after edge t+NUM_STAGE+1. Every register is gated by ce.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high; clears all state
//   ce         in   clock enable; all registers hold while low
//   in_valid   in   beat qualifier
//   in_first   in   first beat of a packet (qualified by in_valid)
//   in_last    in   last beat of a packet (qualified by in_valid)
//   din0       in   LANES x DIN0_WIDTH signed operands, lane i at [i*DIN0_WIDTH +: DIN0_WIDTH]
//   din1       in   LANES x DIN1_WIDTH operands, lane i at [i*DIN1_WIDTH +: DIN1_WIDTH]
//   out_valid  out  one ce-qualified cycle result strobe
//   dout       out  LANES x DOUT_WIDTH signed packet sums
//   ovf        out  per-lane overflow flag of the reported packet
//
// Build option:
//   MYPROJECT_MAC_SAT_EN  defined: accumulator clamps on overflow and stays
//                         clamped until the next first beat.
//                         undefined: accumulator wraps modulo 2^DOUT_WIDTH.
//   ovf is reported in both builds.

module myproject_mac_lanes #(
  parameter int LANES       = 4,
  parameter int DIN0_WIDTH  = 16,
  parameter int DIN1_WIDTH  = 16,
  parameter int DIN1_SIGNED = 0,
  parameter int DOUT_WIDTH  = 40,
  parameter int NUM_STAGE   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ce,
  input  logic                          in_valid,
  input  logic                          in_first,
  input  logic                          in_last,
  input  logic [LANES*DIN0_WIDTH-1:0]   din0,
  input  logic [LANES*DIN1_WIDTH-1:0]   din1,
  output logic                          out_valid,
  output logic [LANES*DOUT_WIDTH-1:0]   dout,
  output logic [LANES-1:0]              ovf
);

  // One extra bit so a zero-extended unsigned din1 is still a valid signed value.
  localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 1;

`ifdef MYPROJECT_MAC_SAT_EN
  localparam logic signed [DOUT_WIDTH-1:0] ACC_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [DOUT_WIDTH-1:0] ACC_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
`endif

  // Operand register
  logic [DIN0_WIDTH-1:0] opa_q [LANES];
  logic [DIN1_WIDTH-1:0] opb_q [LANES];
  logic                  op_vld_q, op_fst_q, op_lst_q;

  // Product pipeline
  logic signed [PW-1:0]         a_x    [LANES];
  logic signed [PW-1:0]         b_x    [LANES];
  logic signed [PW-1:0]         p_x    [LANES];
  logic signed [DOUT_WIDTH-1:0] prod_d [LANES];
  logic signed [DOUT_WIDTH-1:0] prod_q [NUM_STAGE][LANES];
  logic [NUM_STAGE-1:0]         vld_q, fst_q, lst_q;

  // Accumulate stage
  logic                         acc_vld, acc_fst, acc_lst;
  logic signed [DOUT_WIDTH-1:0] acc_q   [LANES];
  logic signed [DOUT_WIDTH-1:0] acc_d   [LANES];
  logic signed [DOUT_WIDTH-1:0] base    [LANES];
  logic signed [DOUT_WIDTH-1:0] sum     [LANES];
  logic signed [DOUT_WIDTH-1:0] acc_nxt [LANES];
  logic [LANES-1:0]             step_ovf, sticky;
  logic [LANES-1:0]             sovf_q, sovf_d;
  logic [LANES-1:0]             ovf_q, ovf_d;
  logic [LANES*DOUT_WIDTH-1:0]  dout_q, dout_d;
  logic                         out_valid_q, out_valid_d;
  logic                         pkt_open_q, pkt_open_d;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      a_x[i] = PW'($signed(opa_q[i]));
      if (DIN1_SIGNED != 0) begin
        b_x[i] = PW'($signed(opb_q[i]));
      end else begin
        b_x[i] = $signed(PW'({1'b0, opb_q[i]}));
      end
      p_x[i] = a_x[i] * b_x[i];
      // The true product fits DIN0_WIDTH+DIN1_WIDTH bits, so this never loses value.
      prod_d[i] = DOUT_WIDTH'(p_x[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_vld_q <= 1'b0;
      op_fst_q <= 1'b0;
      op_lst_q <= 1'b0;
      vld_q    <= '0;
      fst_q    <= '0;
      lst_q    <= '0;
      for (int i = 0; i < LANES; i++) begin
        opa_q[i] <= '0;
        opb_q[i] <= '0;
      end
      for (int s = 0; s < NUM_STAGE; s++) begin
        for (int i = 0; i < LANES; i++) begin
          prod_q[s][i] <= '0;
        end
      end
    end else if (ce) begin
      op_vld_q <= in_valid;
      op_fst_q <= in_valid & in_first;
      op_lst_q <= in_valid & in_last;
      for (int i = 0; i < LANES; i++) begin
        opa_q[i]     <= din0[i*DIN0_WIDTH +: DIN0_WIDTH];
        opb_q[i]     <= din1[i*DIN1_WIDTH +: DIN1_WIDTH];
        prod_q[0][i] <= prod_d[i];
      end
      vld_q[0] <= op_vld_q;
      fst_q[0] <= op_fst_q;
      lst_q[0] <= op_lst_q;
      for (int s = 1; s < NUM_STAGE; s++) begin
        for (int i = 0; i < LANES; i++) begin
          prod_q[s][i] <= prod_q[s-1][i];
        end
        vld_q[s] <= vld_q[s-1];
        fst_q[s] <= fst_q[s-1];
        lst_q[s] <= lst_q[s-1];
      end
    end
  end

  assign acc_vld = vld_q[NUM_STAGE-1];
  assign acc_fst = fst_q[NUM_STAGE-1];
  assign acc_lst = lst_q[NUM_STAGE-1];

  always_comb begin
    dout_d      = dout_q;
    ovf_d       = ovf_q;
    sovf_d      = sovf_q;
    out_valid_d = acc_vld & acc_lst;
    pkt_open_d  = pkt_open_q;
    for (int i = 0; i < LANES; i++) begin
      // A first beat restarts from zero, silently dropping any open partial sum.
      base[i]     = acc_fst ? '0 : acc_q[i];
      sum[i]      = base[i] + prod_q[NUM_STAGE-1][i];
      // Overflow: both addends share a sign and the result sign differs.
      step_ovf[i] = (base[i][DOUT_WIDTH-1] == prod_q[NUM_STAGE-1][i][DOUT_WIDTH-1]) &&
                    (sum[i][DOUT_WIDTH-1] != base[i][DOUT_WIDTH-1]);
      sticky[i]   = (~acc_fst & sovf_q[i]) | step_ovf[i];
`ifdef MYPROJECT_MAC_SAT_EN
      if (!acc_fst && sovf_q[i]) begin
        acc_nxt[i] = acc_q[i];
      end else if (step_ovf[i]) begin
        acc_nxt[i] = base[i][DOUT_WIDTH-1] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_nxt[i] = sum[i];
      end
`else
      acc_nxt[i] = sum[i];
`endif
      acc_d[i] = acc_vld ? acc_nxt[i] : acc_q[i];
      if (acc_vld) begin
        sovf_d[i] = sticky[i];
      end
      if (acc_vld && acc_lst) begin
        dout_d[i*DOUT_WIDTH +: DOUT_WIDTH] = acc_nxt[i];
        ovf_d[i]                           = sticky[i];
      end
    end
    if (acc_vld) begin
      if (acc_lst) begin
        pkt_open_d = 1'b0;
      end else if (acc_fst) begin
        pkt_open_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= '0;
      end
      sovf_q      <= '0;
      ovf_q       <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      pkt_open_q  <= 1'b0;
    end else if (ce) begin
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= acc_d[i];
      end
      sovf_q      <= sovf_d;
      ovf_q       <= ovf_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      pkt_open_q  <= pkt_open_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

  // A packet is never left open once a last beat has been accumulated.
  ap_last_closes: assert property (@(posedge clk) disable iff (reset)
    (ce && acc_vld && acc_lst) |=> !pkt_open_q);

endmodule

// File: tb/tb_myproject_mac_lanes.sv
module tb_myproject_mac_lanes;

  localparam int LANES = 4;
  localparam int W0    = 16;
  localparam int W1    = 16;
  localparam int DW    = 32;
  localparam int DWS   = 40;
  localparam int NS    = 2;
`ifdef MYPROJECT_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam longint MAXV = (longint'(1) <<< (DW-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (DW-1));

  logic                  clk = 1'b0;
  logic                  reset, ce, in_valid, in_first, in_last;
  logic [LANES*W0-1:0]   din0;
  logic [LANES*W1-1:0]   din1;
  logic                  out_valid, out_valid_s;
  logic [LANES*DW-1:0]   dout;
  logic [LANES*DWS-1:0]  dout_s;
  logic [LANES-1:0]      ovf, ovf_s;

  always #5 clk = ~clk;

  myproject_mac_lanes #(.LANES(LANES), .DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .DIN1_SIGNED(0),
                        .DOUT_WIDTH(DW), .NUM_STAGE(NS)) u_dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .din0(din0), .din1(din1), .out_valid(out_valid), .dout(dout), .ovf(ovf));

  myproject_mac_lanes #(.LANES(LANES), .DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .DIN1_SIGNED(1),
                        .DOUT_WIDTH(DWS), .NUM_STAGE(NS)) u_dut_s (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .din0(din0), .din1(din1), .out_valid(out_valid_s), .dout(dout_s), .ovf(ovf_s));

  typedef struct {
    logic [LANES*DW-1:0] d;
    logic [LANES-1:0]    o;
    int                  cyc;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  int     checks = 0;
  int     failures = 0;
  int     pulse_cnt = 0;
  int     cyc = 0;
  longint m_acc [LANES];
  bit     m_sov [LANES];
  logic   hold_pend = 1'b0;
  logic [LANES*DW-1:0] hold_d;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: a result is consumed on a cycle where out_valid is high and ce is high.
  always @(negedge clk) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        checks++;
        if (out_valid !== 1'b1 || dout !== hold_d) begin
          failures++;
          $display("FAIL hold_ce_low: out_valid=%b dout=%h, required out_valid=1 dout=%h", out_valid, dout, hold_d);
        end
      end
      hold_pend = out_valid && !ce;
      hold_d    = dout;
      if (out_valid && ce) begin
        pulse_cnt++;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out_valid: dout=%h at cycle %0d, required no result", dout, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          if (dout !== mon_e.d || ovf !== mon_e.o) begin
            failures++;
            $display("FAIL result: dout=%h ovf=%b, required dout=%h ovf=%b", dout, ovf, mon_e.d, mon_e.o);
          end
          if (mon_e.cyc >= 0) begin
            checks++;
            if (cyc !== mon_e.cyc) begin
              failures++;
              $display("FAIL latency: out_valid at cycle %0d, required cycle %0d", cyc, mon_e.cyc);
            end
          end
        end
      end
    end
  end

  function automatic logic [63:0] pk(input int v0, input int v1, input int v2, input int v3);
    return {v3[15:0], v2[15:0], v1[15:0], v0[15:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) begin
      m_acc[i] = 0;
      m_sov[i] = 1'b0;
    end
  endtask

  task automatic send_beat(input bit f, input bit l, input logic [63:0] a, input logic [63:0] b,
                           input bit rnd);
    exp_t   e;
    int     tries;
    longint p, s;
    logic signed [DW-1:0] w;
    @(posedge clk); #1;
    in_valid = 1'b1; in_first = f; in_last = l; din0 = a; din1 = b;
    ce = 1'b1;
    if (rnd) begin
      tries = 0;
      ce = 1'($urandom_range(0, 1));
      while (!ce && tries < 16) begin
        @(posedge clk); #1;
        tries++;
        ce = 1'($urandom_range(0, 1));
      end
      ce = 1'b1;
    end
    for (int i = 0; i < LANES; i++) begin
      p = longint'($signed(a[i*W0 +: W0])) * longint'({1'b0, b[i*W1 +: W1]});
      if (f) begin
        m_acc[i] = p;
        m_sov[i] = 1'b0;
      end else if (!(SAT && m_sov[i])) begin
        s = m_acc[i] + p;
        if (s > MAXV || s < MINV) begin
          m_sov[i] = 1'b1;
          if (SAT) begin
            m_acc[i] = (s > MAXV) ? MAXV : MINV;
          end else begin
            w = s[DW-1:0];
            m_acc[i] = longint'(w);
          end
        end else begin
          m_acc[i] = s;
        end
      end
    end
    if (l) begin
      for (int i = 0; i < LANES; i++) begin
        e.d[i*DW +: DW] = m_acc[i][DW-1:0];
        e.o[i]          = m_sov[i];
      end
      e.cyc = rnd ? -1 : cyc + NS + 2;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle(input int n, input bit rnd);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      ce = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 60) begin
      idle(1, 1'b0);
      k++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d results pending, required 0", sb_q.size());
      sb_q.delete();
    end
    idle(3, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    din0 = '0; din1 = '0;
    model_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || dout !== '0 || ovf !== '0 || out_valid_s !== 1'b0 || dout_s !== '0) begin
      failures++;
      $display("FAIL reset_state: out_valid=%b dout=%h ovf=%b, required 0/0/0", out_valid, dout, ovf);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(2, 1'b0);
  endtask

  task automatic test_single();
    int  p0 = pulse_cnt;
    bit  seen = 1'b0;
    send_beat(1'b1, 1'b1, pk('hFFFD, 0, 0, 0), pk('hFFFF, 0, 0, 0), 1'b0);
    idle(1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid_s && !seen) begin
        seen = 1'b1;
        checks++;
        if (dout_s[DWS-1:0] !== 40'sd3 || ovf_s[0] !== 1'b0) begin
          failures++;
          $display("FAIL single_signed: dout=%0d ovf=%b, required 3 ovf=0", $signed(dout_s[DWS-1:0]), ovf_s[0]);
        end
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL single_signed_timeout: out_valid seen=0, required 1");
    end
    wait_drain();
    checks++;
    if ($signed(dout[DW-1:0]) !== -32'sd196605 || pulse_cnt - p0 !== 1) begin
      failures++;
      $display("FAIL single_unsigned: dout=%0d pulses=%0d, required -196605 pulses=1",
               $signed(dout[DW-1:0]), pulse_cnt - p0);
    end
  endtask

  task automatic test_packet(input bit rnd);
    int p0 = pulse_cnt;
    for (int b = 0; b < 4; b++) begin
      send_beat(b == 0, b == 3, pk(1, 2, 3, 4), pk(10, 10, 10, 10), rnd);
    end
    if (rnd) idle(8, 1'b1);
    wait_drain();
    checks++;
    if (dout !== {32'd160, 32'd120, 32'd80, 32'd40} || pulse_cnt - p0 !== 1) begin
      failures++;
      $display("FAIL packet4 rnd=%0d: dout=%h pulses=%0d, required dout=%h pulses=1", rnd, dout,
               pulse_cnt - p0, {32'd160, 32'd120, 32'd80, 32'd40});
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] want0;
    want0 = SAT ? 32'h7FFF_FFFF : 32'hFFFD_0002;
    send_beat(1'b1, 1'b0, pk('h7FFF, 'h8000, 5, 0), pk('hFFFF, 'hFFFF, 7, 0), 1'b0);
    send_beat(1'b0, 1'b1, pk('h7FFF, 'h8000, 5, 0), pk('hFFFF, 'hFFFF, 7, 0), 1'b0);
    wait_drain();
    checks++;
    if (dout[DW-1:0] !== want0 || ovf !== 4'b0011) begin
      failures++;
      $display("FAIL overflow: lane0=%h ovf=%b, required lane0=%h ovf=0011", dout[DW-1:0], ovf, want0);
    end
    send_beat(1'b1, 1'b1, pk(1, 1, 1, 1), pk(1, 1, 1, 1), 1'b0);
    wait_drain();
    checks++;
    if (dout !== {32'd1, 32'd1, 32'd1, 32'd1} || ovf !== 4'b0000) begin
      failures++;
      $display("FAIL after_overflow: dout=%h ovf=%b, required all 1 ovf=0000", dout, ovf);
    end
  endtask

  task automatic test_reset_mid();
    send_beat(1'b1, 1'b0, pk(3, 3, 3, 3), pk(3, 3, 3, 3), 1'b0);
    send_beat(1'b0, 1'b0, pk(3, 3, 3, 3), pk(3, 3, 3, 3), 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    reset = 1'b1;
    model_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || dout !== '0 || ovf !== '0) begin
      failures++;
      $display("FAIL reset_mid: out_valid=%b dout=%h ovf=%b, required 0/0/0", out_valid, dout, ovf);
    end
    #1 reset = 1'b0;
    idle(6, 1'b0);
    send_beat(1'b1, 1'b1, pk(5, 5, 5, 5), pk(5, 5, 5, 5), 1'b0);
    wait_drain();
    checks++;
    if (dout !== {32'd25, 32'd25, 32'd25, 32'd25}) begin
      failures++;
      $display("FAIL after_reset_mid: dout=%h, required all 25", dout);
    end
  endtask

  task automatic test_back_to_back();
    int p0 = pulse_cnt;
    send_beat(1'b1, 1'b0, pk(1, 1, 1, 1), pk(1, 1, 1, 1), 1'b0);
    send_beat(1'b0, 1'b1, pk(2, 2, 2, 2), pk(2, 2, 2, 2), 1'b0);
    send_beat(1'b1, 1'b1, pk(3, 3, 3, 3), pk(3, 3, 3, 3), 1'b0);
    wait_drain();
    checks++;
    if (dout !== {32'd9, 32'd9, 32'd9, 32'd9} || pulse_cnt - p0 !== 2) begin
      failures++;
      $display("FAIL back_to_back: dout=%h pulses=%0d, required all 9 pulses=2", dout, pulse_cnt - p0);
    end
  endtask

  task automatic test_last_without_first();
    send_beat(1'b0, 1'b1, pk(2, -1, 4, 0), pk(3, 3, 3, 3), 1'b0);
    wait_drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_packet(1'b0);
    test_overflow();
    test_packet(1'b1);
    test_reset_mid();
    test_back_to_back();
    test_last_without_first();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
